ncore_result_dump: RTL and testbench
====================================

Name: ncore_result_dump

Overview:
- Downstream stage of the ncore core. Once a program run completes, it reads the result window at the top of the core's 256-byte data RAM and streams it out as a byte stream.
- It scans from the highest address downwards: by default ram[255] first, then 254, and so on down to 192.
- It reads the RAM through a synchronous read port with 1-cycle latency. The output is a valid/ready byte stream that feeds the host-facing transmitter.

Parameters:
- AW, 8, RAM address width; all address arithmetic is modulo 2^AW.
- TOP_ADDR, 255, first (highest) address read.
- DUMP_LEN, 64, number of bytes dumped; legal range 1..2^AW.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  single-cycle request to begin a dump; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until DONE is exited
- done  out  1  one-cycle pulse in the DONE state
- ram_rd_en  out  1  RAM read strobe
- ram_addr  out  AW  RAM read address
- ram_rdata  in  8  RAM read data, valid the cycle after ram_rd_en
- out_valid  out  1  output byte valid
- out_data  out  8  output byte
- out_ready  in  1  downstream accept
- out_last  out  1  marks the final byte of the dump; qualified by out_valid

Behaviour:
- Reset: rst sampled high forces state IDLE and clears the following:
  - count=0
  - busy, done, ram_rd_en, out_valid, out_last all 0
  - ram_addr=0, out_data=0
- Reset mid-dump aborts immediately: no done pulse, no further bytes.
- States: IDLE, READ, WAIT, HOLD, DONE.
- IDLE:
  - start=1 -> READ, count=0.
  - busy rises in the READ cycle.
- READ (1 cycle):
  - ram_rd_en=1, ram_addr = (TOP_ADDR - count) mod 2^AW.
  - -> WAIT.
- WAIT (1 cycle):
  - ram_rd_en=0.
  - ram_rdata is registered into out_data at the end of this cycle.
  - out_valid=1 from the next cycle.
  - -> HOLD.
- HOLD:
  - out_valid=1; out_data and out_last are held stable until out_valid & out_ready.
  - out_last=1 iff count == DUMP_LEN-1.
  - On handshake, non-last byte: count+1, -> READ.
  - On handshake, last byte: -> DONE.
  - out_valid drops in the cycle after the handshake.
- DONE (1 cycle): done=1, busy=1, out_valid=0; -> IDLE.
- Throughput: minimum 3 cycles per byte with out_ready tied high. First out_valid appears 3 cycles after start is sampled.
- start while not in IDLE is ignored; it is not queued.
- out_ready held low stalls indefinitely in HOLD with no RAM reads issued.
- Address wrap: if DUMP_LEN > TOP_ADDR+1, the address wraps modulo 2^AW (e.g. TOP_ADDR=3, DUMP_LEN=6 reads 3,2,1,0,255,254).
- count is wide enough to hold DUMP_LEN-1. ram_addr holds its last value outside READ.

Optional Feature:
- Macro NCORE_DUMP_ASCII_EN.
- Defined: each RAM byte is emitted as three characters:
  - high-nibble lowercase hex ASCII ('0'-'9' = 0x30-0x39, 'a'-'f' = 0x61-0x66);
  - then the low-nibble character;
  - then a space (0x20).
- Each character uses its own valid/ready handshake, via sub-states HI, LO, SP replacing HOLD.
- After the final byte's space, one newline (0x0A) is emitted. out_last=1 only on that newline.
- Total characters = 3*DUMP_LEN + 1 (193 at default).
- Not defined: raw binary bytes as described in Behaviour; no separators.

Test Plan:
- Reset values: preload ram[255]=0xA5 and ram[192]=0x3C, out_ready=1, pulse start -> 64 bytes.
  - First byte 0xA5 and last byte 0x3C; out_last only on byte 64.
  - Exactly one done pulse; busy low afterwards.
- Backpressure: out_ready=0 for 10 cycles while in HOLD on byte 0 -> out_valid stays 1, out_data stays 0xA5, ram_rd_en stays 0. Release -> byte 1 = ram[254].
- Mid-dump reset: assert rst after byte 5 is accepted -> next cycle all outputs 0, no done pulse. A new start re-dumps from ram[255].
- Start ignored: pulse start during byte 10 -> dump completes with exactly 64 bytes and one done pulse.
- Wrap: TOP_ADDR=3, DUMP_LEN=6 -> read order on ram_addr is 3,2,1,0,255,254; out_last on the 6th byte.
- ASCII (NCORE_DUMP_ASCII_EN): ram[255]=0x0F, ram[254]=0xB2, DUMP_LEN=2 -> 0x30,0x66,0x20,0x62,0x32,0x20,0x0A, with out_last on 0x0A.

Source files
------------

// File: rtl/ncore_result_dump.sv
// ncore_result_dump
//   Once a program run has finished, reads the result window at the top of
//   the core's data RAM (TOP_ADDR downwards, DUMP_LEN bytes, addresses wrap
//   modulo 2^AW) and streams it out as a valid/ready byte stream.
//
//   Build option NCORE_DUMP_ASCII_EN: each RAM byte is emitted as two
//   lowercase hex characters plus a space, and the dump ends with a newline.
//   Without it, raw bytes are emitted with no separators.
//
// Ports
//   clk_i        rising-edge clock
//   rst_i        synchronous active-high reset
//   start_i      single-cycle dump request, only looked at while idle
//   busy_o       high from the first read cycle until the done cycle ends
//   done_o       one-cycle completion pulse
//   ram_rd_en_o  RAM read strobe
//   ram_addr_o   RAM read address (holds its last value between reads)
//   ram_rdata_i  RAM read data, one cycle after ram_rd_en_o
//   out_valid_o  output byte valid
//   out_data_o   output byte
//   out_ready_i  downstream accept
//   out_last_o   final byte of the dump, qualified by out_valid_o
module ncore_result_dump #(
    parameter int AW       = 8,
    parameter int TOP_ADDR = 255,
    parameter int DUMP_LEN = 64
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    output logic          busy_o,
    output logic          done_o,
    output logic          ram_rd_en_o,
    output logic [AW-1:0] ram_addr_o,
    input  logic [7:0]    ram_rdata_i,
    output logic          out_valid_o,
    output logic [7:0]    out_data_o,
    input  logic          out_ready_i,
    output logic          out_last_o
);

    localparam int             CW       = (DUMP_LEN > 1) ? $clog2(DUMP_LEN) : 1;
    localparam logic [CW-1:0]  LAST_CNT = CW'(DUMP_LEN - 1);
    localparam logic [AW-1:0]  TOP_A    = AW'(TOP_ADDR);

`ifdef NCORE_DUMP_ASCII_EN
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_HI, S_LO, S_SP, S_NL, S_DONE
    } state_t;

    // Lowercase hex digit for one nibble.
    function automatic logic [7:0] hex_chr(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    logic [3:0] lo_q, lo_d;   // low nibble parked while the high digit is out
`else
    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_WAIT, S_HOLD, S_DONE
    } state_t;
`endif

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    data_q, data_d;
    logic          hs;
    logic          is_last;
    logic [CW-1:0] cnt_inc;

    assign busy_o      = (state_q != S_IDLE);
    assign done_o      = (state_q == S_DONE);
    assign ram_rd_en_o = (state_q == S_READ);
    assign ram_addr_o  = addr_q;
    assign out_data_o  = data_q;
    assign is_last     = (count_q == LAST_CNT);
    assign cnt_inc     = count_q + CW'(1);
`ifdef NCORE_DUMP_ASCII_EN
    assign out_valid_o = (state_q == S_HI) || (state_q == S_LO) ||
                         (state_q == S_SP) || (state_q == S_NL);
    assign out_last_o  = (state_q == S_NL);
`else
    assign out_valid_o = (state_q == S_HOLD);
    assign out_last_o  = (state_q == S_HOLD) && is_last;
`endif
    assign hs = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
`ifdef NCORE_DUMP_ASCII_EN
        lo_d    = lo_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_READ;
                    count_d = '0;
                    addr_d  = TOP_A;
                end
            end
            S_READ: state_d = S_WAIT;
`ifdef NCORE_DUMP_ASCII_EN
            S_WAIT: begin
                data_d  = hex_chr(ram_rdata_i[7:4]);
                lo_d    = ram_rdata_i[3:0];
                state_d = S_HI;
            end
            S_HI: if (hs) begin
                data_d  = hex_chr(lo_q);
                state_d = S_LO;
            end
            S_LO: if (hs) begin
                data_d  = 8'h20;
                state_d = S_SP;
            end
            S_SP: if (hs) begin
                if (is_last) begin
                    data_d  = 8'h0A;
                    state_d = S_NL;
                end else begin
                    count_d = cnt_inc;
                    addr_d  = TOP_A - AW'(cnt_inc);
                    state_d = S_READ;
                end
            end
            S_NL: if (hs) state_d = S_DONE;
`else
            S_WAIT: begin
                data_d  = ram_rdata_i;
                state_d = S_HOLD;
            end
            S_HOLD: if (hs) begin
                if (is_last) begin
                    state_d = S_DONE;
                end else begin
                    count_d = cnt_inc;
                    // address arithmetic wraps naturally in AW bits
                    addr_d  = TOP_A - AW'(cnt_inc);
                    state_d = S_READ;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
`ifdef NCORE_DUMP_ASCII_EN
            lo_q    <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
`ifdef NCORE_DUMP_ASCII_EN
            lo_q    <= lo_d;
`endif
        end
    end

endmodule

// File: tb/tb_ncore_result_dump.sv
// Bench for ncore_result_dump: three instances (default window, a wrapping
// 6-byte window at address 3, and a 2-byte window) share a RAM model. The
// expected stream is built from the RAM contents with plain arithmetic.
module tb_ncore_result_dump;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start [3];
    logic       busy  [3];
    logic       done  [3];
    logic       rd_en [3];
    logic       valid [3];
    logic       ready [3];
    logic       last  [3];
    logic [7:0] addr  [3];
    logic [7:0] rdata [3];
    logic [7:0] data  [3];
    logic [7:0] mem   [256];

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] exp_d [$];
    logic [7:0] got_d [$];

    function automatic int top_of(input int k);
        case (k)
            1:       return 3;
            default: return 255;
        endcase
    endfunction

    function automatic int len_of(input int k);
        case (k)
            0:       return 64;
            1:       return 6;
            default: return 2;
        endcase
    endfunction

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ncore_result_dump #(
            .AW(8), .TOP_ADDR(top_of(g)), .DUMP_LEN(len_of(g))
        ) u_dut (
            .clk_i(clk), .rst_i(rst), .start_i(start[g]), .busy_o(busy[g]),
            .done_o(done[g]), .ram_rd_en_o(rd_en[g]), .ram_addr_o(addr[g]),
            .ram_rdata_i(rdata[g]), .out_valid_o(valid[g]), .out_data_o(data[g]),
            .out_ready_i(ready[g]), .out_last_o(last[g])
        );
    end

    // synchronous RAM, one-cycle read latency
    always @(posedge clk)
        for (int k = 0; k < 3; k++)
            if (rd_en[k]) rdata[k] <= mem[addr[k]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] hexc(input logic [3:0] n);
        return (n < 4'd10) ? (8'd48 + 8'(n)) : (8'd87 + 8'(n));
    endfunction

    task automatic build_exp(input int k);
        logic [7:0] b;
        exp_d.delete();
        for (int i = 0; i < len_of(k); i++) begin
            b = mem[(top_of(k) - i) & 255];
`ifdef NCORE_DUMP_ASCII_EN
            exp_d.push_back(hexc(b[7:4]));
            exp_d.push_back(hexc(b[3:0]));
            exp_d.push_back(8'h20);
`else
            exp_d.push_back(b);
`endif
        end
`ifdef NCORE_DUMP_ASCII_EN
        exp_d.push_back(8'h0A);
`endif
    endtask

    task automatic chk_zero(input int k, input string tag);
        chk({tag, "_busy"},  busy[k],  0);
        chk({tag, "_done"},  done[k],  0);
        chk({tag, "_rd_en"}, rd_en[k], 0);
        chk({tag, "_addr"},  addr[k],  0);
        chk({tag, "_valid"}, valid[k], 0);
        chk({tag, "_data"},  data[k],  0);
        chk({tag, "_last"},  last[k],  0);
    endtask

    // One dump on instance k. rdy_pct: chance out_ready is high each cycle.
    // inj_at: byte index during which a stray start is pulsed (-1 none).
    // rst_at: reset right after this byte is accepted (-1 none).
    // stall_at: byte index held with out_ready low for 10 cycles (-1 none).
    task automatic run_dump(input int k, input int rdy_pct, input int inj_at,
                            input int rst_at, input int stall_at);
        int got, dones, cyc, first_v, rd_n, stall_n, vcnt;
        logic pv, pl, injected, do_rst, fin;
        logic [7:0] pd;
        got = 0; dones = 0; first_v = -1; rd_n = 0; stall_n = 0;
        pv = 0; pl = 0; pd = 0; injected = 0; do_rst = 0; fin = 0;
        build_exp(k);
        got_d.delete();
        start[k] = 1'b1;
        @(posedge clk); #1;
        start[k] = 1'b0;
        chk("busy_rise", busy[k], 1);
        cyc = 1;
        while (!fin && cyc < 3000) begin
            if (do_rst) begin
                rst = 1'b1;
                ready[k] = 1'b1;
                @(posedge clk); #1;
                chk_zero(k, "midrst");
                rst = 1'b0;
                dones = 0; vcnt = 0;
                repeat (20) begin
                    @(posedge clk); #1;
                    if (done[k])  dones++;
                    if (valid[k]) vcnt++;
                end
                chk("midrst_no_done", dones, 0);
                chk("midrst_no_valid", vcnt, 0);
                ready[k] = 1'b0;
                return;
            end
            if (cyc == 1) chk("rd_first", rd_en[k], 1);
            if (rd_en[k]) begin
                chk("rd_addr", addr[k], (top_of(k) - rd_n) & 255);
                rd_n++;
            end
            if (valid[k] && first_v < 0) first_v = cyc;
            if (pv) begin
                chk("hold_valid", valid[k], 1);
                chk("hold_data", data[k], pd);
                chk("hold_last", last[k], pl);
                chk("hold_no_rd", rd_en[k], 0);
            end
            if (done[k]) begin
                dones++;
                chk("done_busy", busy[k], 1);
                chk("done_valid", valid[k], 0);
            end else if (dones > 0) begin
                chk("busy_after", busy[k], 0);
                fin = 1;
            end
            if (stall_at == got && valid[k] && stall_n < 10) begin
                ready[k] = 1'b0;
                stall_n++;
            end else begin
                ready[k] = ($urandom_range(99) < rdy_pct);
            end
            pv = 0;
            if (valid[k] && ready[k]) begin
                if (got < exp_d.size()) chk("data", data[k], exp_d[got]);
                else                    chk("extra_byte", got, exp_d.size() - 1);
                chk("last", last[k], got == exp_d.size() - 1);
                got_d.push_back(data[k]);
                got++;
                if (got == rst_at + 1) do_rst = 1;
            end else if (valid[k]) begin
                pv = 1; pd = data[k]; pl = last[k];
            end
            if (!injected && inj_at >= 0 && got == inj_at && valid[k]) begin
                start[k] = 1'b1;
                injected = 1;
            end else begin
                start[k] = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        ready[k] = 1'b0;
        start[k] = 1'b0;
        chk("no_timeout", fin, 1);
        chk("n_bytes", got, exp_d.size());
        chk("n_done", dones, 1);
        chk("first_valid_cyc", first_v, 3);
    endtask

    initial begin
        logic [7:0] av [7];
        for (int k = 0; k < 3; k++) begin
            start[k] = 1'b0;
            ready[k] = 1'b0;
        end
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[255] = 8'hA5;
        mem[192] = 8'h3C;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_zero(0, "rst");
        chk_zero(1, "rst1");
        rst = 1'b0;
        @(posedge clk); #1;

        // full-speed dump
        run_dump(0, 100, -1, -1, -1);
`ifndef NCORE_DUMP_ASCII_EN
        chk("first_byte", got_d[0], 8'hA5);
        chk("last_byte", got_d[63], 8'h3C);
`endif
        // backpressure on byte 0
        run_dump(0, 100, -1, -1, 0);
`ifndef NCORE_DUMP_ASCII_EN
        chk("bp_byte1", got_d[1], mem[254]);
`endif
        // stray start mid-dump
        run_dump(0, 100, 10, -1, -1);
        // reset after byte 5, then a clean re-dump
        run_dump(0, 100, -1, 5, -1);
        run_dump(0, 100, -1, -1, -1);
        // fresh random contents with random backpressure
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        run_dump(0, 50, -1, -1, -1);
        // wrapping window: reads 3,2,1,0,255,254
        run_dump(1, 100, -1, -1, -1);
        run_dump(1, 40, -1, -1, 2);
        // 2-byte window
        mem[255] = 8'h0F;
        mem[254] = 8'hB2;
        run_dump(2, 100, -1, -1, -1);
`ifdef NCORE_DUMP_ASCII_EN
        av = '{8'h30, 8'h66, 8'h20, 8'h62, 8'h32, 8'h20, 8'h0A};
        chk("ascii_len", got_d.size(), 7);
        for (int i = 0; i < 7; i++)
            chk("ascii_chr", (i < got_d.size()) ? got_d[i] : 8'hxx, av[i]);
`else
        av = '{8'h0F, 8'hB2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        chk("w2_len", got_d.size(), 2);
        for (int i = 0; i < 2; i++)
            chk("w2_byte", (i < got_d.size()) ? got_d[i] : 8'hxx, av[i]);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
